// File: rtl/trax_move_parser.sv
// Trax referee line parser: turns ASCII move and colour lines from the UART
// byte stream into the controller's {tile, col, row} move word and colour bit.
module trax_move_parser #(
  parameter int unsigned COORD_W    = 10,
  parameter int unsigned MAX_TOKENS = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic [2*COORD_W+1:0]   move_out,
  output logic                   move_valid,
  output logic                   color,
  output logic                   color_valid,
  output logic                   parse_error
);

  localparam int unsigned AW = COORD_W + 6;
  localparam int unsigned TW = $clog2(MAX_TOKENS + 1);
  localparam logic [AW-1:0] COORD_MAX = AW'((1 << COORD_W) - 1);
  localparam logic [TW-1:0] TOK_LIMIT = TW'(MAX_TOKENS);

  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_DASH  = 8'h2D;
  localparam logic [7:0] CH_AT    = 8'h40;
  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_SLASH = 8'h2F;
  localparam logic [7:0] CH_BSL   = 8'h5C;
  localparam logic [7:0] CH_ZERO  = 8'h30;
  localparam logic [7:0] CH_W     = 8'h57;
  localparam logic [7:0] CH_B     = 8'h42;

  typedef enum logic [3:0] {
    IDLE,
    COLOR,
    EOL_C,
    COL_AT,
    COL,
    ROW,
    ROW_Z,
    EOL_M,
    ERR
  } state_t;

  state_t          state;
  logic [AW-1:0]   col_acc;
  logic [AW-1:0]   row_acc;
  logic [TW-1:0]   tok_cnt;
  logic [1:0]      tile_pend;
  logic            color_pend;

  logic            is_lf;
  logic            is_letter;
  logic            is_digit;
  logic            is_nz_digit;
  logic            is_tile;
  logic            is_wb;
  logic [1:0]      tile_code;
  logic [7:0]      letter_raw;
  logic [7:0]      digit_raw;
  logic [AW-1:0]   letter_val;
  logic [AW-1:0]   digit_val;
  logic [AW-1:0]   col_next;
  logic [AW-1:0]   row_next;
  logic            tok_full;
  logic            step_err;

  // Character classification, next accumulator values and per-state rejection.
  // Every "byte not allowed here" case funnels into step_err so the sequential
  // block handles entry to ERR (and the LF-triggered immediate error) in one place.
  always_comb begin
    is_lf       = (rx_data == CH_LF);
    is_letter   = (rx_data >= 8'h41) && (rx_data <= 8'h5A);
    is_digit    = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    is_nz_digit = is_digit && (rx_data != CH_ZERO);
    is_wb       = (rx_data == CH_W) || (rx_data == CH_B);
    tile_code   = 2'b00;
    case (rx_data)
      CH_PLUS:  tile_code = 2'b01;
      CH_SLASH: tile_code = 2'b10;
      CH_BSL:   tile_code = 2'b11;
      default:  tile_code = 2'b00;
    endcase
    is_tile    = (tile_code != 2'b00);
    letter_raw = rx_data - CH_AT;
    digit_raw  = rx_data - CH_ZERO;
    letter_val = AW'(letter_raw);
    digit_val  = AW'(digit_raw);
    col_next   = col_acc * AW'(26) + letter_val;
    row_next   = row_acc * AW'(10) + digit_val;
    tok_full   = (tok_cnt >= TOK_LIMIT);

    step_err = 1'b0;
    case (state)
      IDLE:    step_err = !((rx_data == CH_DASH) || (rx_data == CH_AT) || is_letter || is_lf);
      COLOR:   step_err = !is_wb;
      EOL_C:   step_err = !is_lf;
      COL_AT:  step_err = (rx_data != CH_ZERO) || tok_full;
      COL: begin
        if (is_letter)        step_err = tok_full || (col_next > COORD_MAX);
        else if (is_nz_digit) step_err = tok_full;
        else                  step_err = 1'b1;
      end
      ROW: begin
        if (is_digit) step_err = tok_full || (row_next > COORD_MAX);
        else          step_err = !is_tile;
      end
      ROW_Z:   step_err = !is_tile;
      EOL_M:   step_err = !is_lf;
      default: step_err = 1'b0;
    endcase
  end

  // Line-parsing FSM with registered strobes and held move/colour outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      col_acc     <= '0;
      row_acc     <= '0;
      tok_cnt     <= '0;
      tile_pend   <= '0;
      color_pend  <= 1'b0;
      move_out    <= '0;
      move_valid  <= 1'b0;
      color       <= 1'b0;
      color_valid <= 1'b0;
      parse_error <= 1'b0;
    end else begin
      move_valid  <= 1'b0;
      color_valid <= 1'b0;
      parse_error <= 1'b0;
      if (rx_valid && (rx_data != CH_CR)) begin
        if (state == ERR) begin
          if (is_lf) begin
            parse_error <= 1'b1;
            state       <= IDLE;
          end
        end else if (step_err) begin
          // An LF that breaks the line reports immediately rather than parking in ERR.
          if (is_lf) begin
            parse_error <= 1'b1;
            state       <= IDLE;
          end else begin
            state <= ERR;
          end
        end else begin
          case (state)
            IDLE: begin
              row_acc <= '0;
              if (rx_data == CH_DASH) begin
                state <= COLOR;
              end else if (rx_data == CH_AT) begin
                col_acc <= '0;
                tok_cnt <= '0;
                state   <= COL_AT;
              end else if (is_letter) begin
                col_acc <= letter_val;
                tok_cnt <= TW'(1);
                state   <= COL;
              end
            end
            COLOR: begin
              color_pend <= (rx_data == CH_B);
              state      <= EOL_C;
            end
            EOL_C: begin
              color       <= color_pend;
              color_valid <= 1'b1;
              state       <= IDLE;
            end
            COL_AT: begin
              row_acc <= '0;
              tok_cnt <= tok_cnt + TW'(1);
              state   <= ROW_Z;
            end
            COL: begin
              tok_cnt <= tok_cnt + TW'(1);
              if (is_letter) begin
                col_acc <= col_next;
              end else begin
                row_acc <= digit_val;
                state   <= ROW;
              end
            end
            ROW: begin
              if (is_digit) begin
                row_acc <= row_next;
                tok_cnt <= tok_cnt + TW'(1);
              end else begin
                tile_pend <= tile_code;
                state     <= EOL_M;
              end
            end
            ROW_Z: begin
              tile_pend <= tile_code;
              state     <= EOL_M;
            end
            EOL_M: begin
              move_out   <= {tile_pend, col_acc[COORD_W-1:0], row_acc[COORD_W-1:0]};
              move_valid <= 1'b1;
              state      <= IDLE;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_trax_move_parser.sv
// Directed bench for trax_move_parser: sends referee lines byte by byte and
// checks strobes and held outputs one cycle after each terminating LF.
module tb_trax_move_parser;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [21:0] move_out;
  logic        move_valid;
  logic        color;
  logic        color_valid;
  logic        parse_error;

  int vectors    = 0;
  int miscompares = 0;
  int mv_cnt     = 0;
  int cv_cnt     = 0;
  int pe_cnt     = 0;
  int multi_cnt  = 0;

  trax_move_parser #(.COORD_W(10), .MAX_TOKENS(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .move_out    (move_out),
    .move_valid  (move_valid),
    .color       (color),
    .color_valid (color_valid),
    .parse_error (parse_error)
  );

  always #5 clk = ~clk;

  // Pulse tallies sampled away from the active edge.
  always @(negedge clk) begin
    if (move_valid)  mv_cnt++;
    if (color_valid) cv_cnt++;
    if (parse_error) pe_cnt++;
    if ((int'(move_valid) + int'(color_valid) + int'(parse_error)) > 1) multi_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_line(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  // Called right after the LF: pulses are visible now and gone a cycle later.
  task automatic check_line(input string tag, input logic mv, input logic cv, input logic pe,
                            input logic [21:0] mo, input logic co);
    chk({tag, ".move_valid"},  32'(move_valid),  32'(mv));
    chk({tag, ".color_valid"}, 32'(color_valid), 32'(cv));
    chk({tag, ".parse_error"}, 32'(parse_error), 32'(pe));
    chk({tag, ".move_out"},    32'(move_out),    32'(mo));
    chk({tag, ".color"},       32'(color),       32'(co));
    @(posedge clk);
    #1;
    chk({tag, ".pulses_drop"}, {29'd0, move_valid, color_valid, parse_error}, 32'd0);
  endtask

  int mv_before;

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    chk("reset.move_out", 32'(move_out), 32'd0);
    chk("reset.pulses", {29'd0, move_valid, color_valid, parse_error}, 32'd0);
    chk("reset.color", 32'(color), 32'd0);

    send_line("-W\n");
    check_line("color_w", 1'b0, 1'b1, 1'b0, 22'h000000, 1'b0);
    send_line("-B\n");
    check_line("color_b", 1'b0, 1'b1, 1'b0, 22'h000000, 1'b1);
    chk("color.cv_count", 32'(cv_cnt), 32'd2);
    chk("color.no_move", 32'(mv_cnt), 32'd0);

    send_line("@0/\n");
    check_line("at0", 1'b1, 1'b0, 1'b0, 22'h200000, 1'b1);

    send_line("A1+\r\n");
    check_line("a1_cr", 1'b1, 1'b0, 1'b0, 22'h100401, 1'b1);

    send_line("AB12\\\n");
    check_line("ab12", 1'b1, 1'b0, 1'b0, 22'h30700C, 1'b1);

    send_line("A1x\n");
    check_line("err_a1x", 1'b0, 1'b0, 1'b1, 22'h30700C, 1'b1);
    send_line("@5+\n");
    check_line("err_at5", 1'b0, 1'b0, 1'b1, 22'h30700C, 1'b1);
    send_line("A01+\n");
    check_line("err_a01", 1'b0, 1'b0, 1'b1, 22'h30700C, 1'b1);
    send_line("B2/\n");
    check_line("b2", 1'b1, 1'b0, 1'b0, 22'h200802, 1'b1);

    send_line("A1024+\n");
    check_line("row_ovf", 1'b0, 1'b0, 1'b1, 22'h200802, 1'b1);
    send_line("A1023/\n");
    check_line("row_max", 1'b1, 1'b0, 1'b0, 22'h2007FF, 1'b1);
    send_line("AMJ1+\n");
    check_line("col_ovf", 1'b0, 1'b0, 1'b1, 22'h2007FF, 1'b1);
    send_line("AMI1+\n");
    check_line("col_max", 1'b1, 1'b0, 1'b0, 22'h1FFC01, 1'b1);

    // LF that itself breaks the line, empty line, junk in IDLE.
    send_line("-\n");
    check_line("lf_err", 1'b0, 1'b0, 1'b1, 22'h1FFC01, 1'b1);
    send_line("\n");
    check_line("empty", 1'b0, 1'b0, 1'b0, 22'h1FFC01, 1'b1);
    send_line("x\n");
    check_line("junk", 1'b0, 1'b0, 1'b1, 22'h1FFC01, 1'b1);
    send_line("-X\n");
    check_line("bad_color", 1'b0, 1'b0, 1'b1, 22'h1FFC01, 1'b1);

    // Idle gaps between bytes must not disturb parsing.
    send("C");
    repeat (3) @(posedge clk);
    #1;
    send("7");
    repeat (2) @(posedge clk);
    #1;
    send("/");
    send(8'h0A);
    check_line("gaps", 1'b1, 1'b0, 1'b0, 22'h200C07, 1'b1);

    send_line("-W\n");
    check_line("color_w2", 1'b0, 1'b1, 1'b0, 22'h200C07, 1'b0);

    // Reset mid-line drops the partial line.
    mv_before = mv_cnt;
    send_line("A12");
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("midreset.move_out", 32'(move_out), 32'd0);
    send_line("C3+\n");
    check_line("c3", 1'b1, 1'b0, 1'b0, 22'h100C03, 1'b0);
    chk("midreset.one_move", 32'(mv_cnt - mv_before), 32'd1);

    chk("pulse_total.pe", 32'(pe_cnt), 32'd8);
    chk("onehot_pulses", 32'(multi_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/trax_move_parser.md
Name: trax_move_parser

Overview:
- Upstream of the Trax game controller; sits between the UART receive byte stream and the controller's move input.
- Parses referee ASCII lines into the controller's 22-bit move word {tile[1:0], col[9:0], row[9:0]}.
- Also parses the colour-assignment line: "-W" = white = 0, "-B" = black = 1.
- Emits single-cycle strobes for each parsed move, colour assignment or parse error.

Parameters:
- COORD_W, 10, width of the row and column fields; values above 2^COORD_W-1 are errors.
- MAX_TOKENS, 8, maximum column letters plus row digits per line before the line is declared an error.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high; clears all state and outputs
- rx_data  input  8  received ASCII byte
- rx_valid  input  1  one-cycle strobe, rx_data valid; no backpressure, one byte per cycle max
- move_out  output  22  {tile, col, row}; tile codes: plus 01, slash 10, bslash 11; held until next move
- move_valid  output  1  one-cycle pulse, move_out updated this cycle
- color  output  1  0 white, 1 black; held
- color_valid  output  1  one-cycle pulse, colour line accepted
- parse_error  output  1  one-cycle pulse, malformed line discarded

Behaviour:
- Reset values: move_out=0, move_valid=0, color=0, color_valid=0, parse_error=0, state=IDLE, col_acc=0, row_acc=0, token count=0.
- All pulses assert exactly 1 cycle after the rx_valid cycle carrying the terminating '\n' (0x0A).
- '\r' (0x0D) is ignored in every state.
- States:
  - IDLE:
    - '-' -> COLOR.
    - '@' -> col=0, COL_AT.
    - 'A'..'Z' -> col=letter-0x40, COL.
    - '\n' -> stay, no pulse (empty line).
    - Else -> ERR.
  - COLOR:
    - 'W' or 'B' -> latch pending colour, go to EOL_C.
    - Else -> ERR.
  - EOL_C:
    - '\n' -> color updated, color_valid pulse, IDLE.
    - Else -> ERR.
  - COL_AT:
    - '0' -> row=0, ROW_Z.
    - Else -> ERR. ("@" is only valid as "@0".)
  - COL:
    - Letter -> col = col*26 + (letter-0x40) (bijective base-26: AA=27).
    - '1'..'9' -> row=digit, ROW.
    - '0' or other -> ERR.
  - ROW:
    - Digit -> row = row*10 + digit.
    - '+', '/', '\' -> latch tile, EOL_M.
    - Else -> ERR.
  - ROW_Z:
    - '+', '/', '\' -> latch tile, EOL_M.
    - Else -> ERR. (No leading zeros.)
  - EOL_M:
    - '\n' -> move_out={tile,col,row}, move_valid pulse, IDLE.
    - Else -> ERR.
  - ERR:
    - Discard bytes until '\n', then parse_error pulse, IDLE.
    - A '\n' that itself causes entry to ERR pulses parse_error on the next cycle and returns to IDLE directly.
- Arithmetic:
  - Accumulate in COORD_W+6 bits.
  - Any col or row result > 2^COORD_W-1 -> ERR immediately.
  - More than MAX_TOKENS letters+digits -> ERR.
- move_out and color change only on their own valid pulse. A rejected line leaves previous values intact.
- rx_valid low: no state change.
- Reset asserted mid-line: the partial line is dropped, no pulse is emitted, and parsing restarts in IDLE with the next byte.
- At most one of move_valid, color_valid, parse_error is high in any cycle.

Test Plan:
- "-W\n" then "-B\n" -> color_valid pulses twice; color=0 after first, 1 after second; no move_valid.
- "@0/\n" -> move_valid 1 cycle after '\n'; move_out=22'h200000.
- "A1+\r\n" -> move_out=22'h100401 (tile 01, col 1, row 1); the CR is ignored.
- "AB12\\n" (AB, 12, backslash) -> move_out=22'h30700C (col 28, row 12, tile 11).
- "A1x\n", then "@5+\n", then "A01+\n" -> three parse_error pulses; move_out unchanged from the prior move; the next "B2/\n" parses to 22'h200802.
- "A1024+\n" -> parse_error (row overflow).
- "A12" then reset, then "C3+\n" -> only one move_valid, with move_out=22'h100C03.
